spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//  SPI slave front-end for the single-port RAM. Deserialises MOSI frames into 10-bit words
//  {cmd[1:0],payload[7:0]} and forwards them on rx_data/rx_valid. Serialises the RAM's read
//  byte (tx_data/tx_valid) back out on MISO. SPI bit clock is clk; one bit per rising edge.
// PARAMETERS
//  FRAME_W  10  bits per MOSI frame (2 cmd + 8 payload)
//  DATA_W    8  bits per MISO read-data byte
// PORTS
//  clk       in   1        system clock = SPI bit clock
//  rst_n     in   1        asynchronous, active-low reset
//  ss_n      in   1        slave select, active low; high ends/aborts a frame
//  mosi      in   1        serial data in, MSB first
//  miso      out  1        serial data out, MSB first; 0 when not driving read data
//  rx_data   out  FRAME_W  assembled frame to RAM
//  rx_valid  out  1        one-cycle strobe, rx_data valid
//  tx_data   in   DATA_W   read byte from RAM
//  tx_valid  in   1        tx_data valid (may stay high for many cycles)
// BEHAVIOUR
//  Reset: rst_n, asynchronous, active-low; clock clk. State=IDLE; miso=0; rx_valid=0;
//   rx_data=0; rd_addr_done=0; bit counter=0; tx_done=0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. All transitions on rising clk.
//  - IDLE: ss_n=0 -> CHK_CMD; else stay.
//  - CHK_CMD: samples mosi as frame bit 9 into shift reg. mosi=0 -> WRITE;
//    mosi=1 & rd_addr_done=0 -> READ_ADD; mosi=1 & rd_addr_done=1 -> READ_DATA.
//  - WRITE/READ_ADD/READ_DATA: shift in bits 8..0, one per edge (9 edges).
//    On edge carrying bit 0: rx_data <= {shift[8:0],mosi}; rx_valid=1 for exactly 1 cycle.
//  - Timing: ss_n sampled low at edge E0; bit9 at E1; bit0 at E10; rx_valid high E10..E11.
//  - cmd bits forwarded verbatim; RAM decodes. rd_addr_done toggles by state, not by bits:
//    set at completion of READ_ADD frame; cleared at completion of MISO byte in READ_DATA.
//  - After frame completes in WRITE/READ_ADD: extra mosi bits ignored until ss_n=1.
//  - READ_DATA after rx_valid: wait for tx_valid=1 with tx_done=0. At edge Ek seeing it:
//    latch tx_data, miso <= tx_data[7], tx_done=1. Edges Ek+1..Ek+7: miso <= bits 6..0.
//    Edge Ek+8: miso <= 0, rd_addr_done <= 0. Further tx_valid ignored in this frame.
//  - ss_n=1 in any non-IDLE state -> IDLE at that edge: counter=0, tx_done=0, miso=0,
//    no rx_valid (partial frame discarded), rd_addr_done unchanged if MISO byte incomplete.
//  - ss_n=1 in the same edge as bit 0: abort wins, no rx_valid.
//  - Counter 4 bits, saturates; no wrap within a frame.
//  - Reset mid-frame: all outputs to reset values immediately (async), frame lost.
// TESTING
//  1 Write addr: ss_n=0, mosi 0,0,0x3C MSB-first -> rx_data=0x03C, rx_valid 1 cycle at E10.
//  2 Write data: mosi 0,1,0xA5 -> rx_data=0x1A5, one rx_valid; rd_addr_done stays 0.
//  3 Read addr: mosi 1,0,0x3C -> rx_data=0x23C, rd_addr_done=1; ss_n=1 -> IDLE.
//  4 Read data: mosi 1,1,0x00 -> rx_data=0x300; tx_valid=1, tx_data=0xA5 held high ->
//    miso 1,0,1,0,0,1,0,1 on 8 consecutive edges, then 0; exactly one byte; rd_addr_done=0.
//  5 Abort: ss_n=1 after 5 bits -> no rx_valid, IDLE; next full write frame 0x1FF correct.
//  6 rst_n=0 mid-MISO byte -> miso=0, rx_valid=0 immediately; next frame uses CHK_CMD path
//    with rd_addr_done=0 (mosi=1 -> READ_ADD).

Source files
------------

// File: rtl/spi_slave_ctrl_if.sv
// SPI slave front-end bus bundle.
//  slave  modport : used by spi_slave_ctrl (samples ss_n/mosi/tx_*, drives miso/rx_*)
//  master modport : used by whoever drives the SPI pins and consumes rx frames
//  ss_n, mosi          : SPI pins in (slave select active low, data MSB first)
//  miso                : SPI data out, MSB first, 0 when idle
//  rx_data / rx_valid  : assembled {cmd[1:0],payload[7:0]} frame + 1-cycle strobe
//  tx_data / tx_valid  : read byte from RAM + its valid level
interface spi_slave_ctrl_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM.
// Deserialises 10-bit MOSI frames {cmd,payload} onto rx_data/rx_valid and, after a
// read-data command, serialises one RAM byte (tx_data) out on MISO.
//  clk   : system clock, also the SPI bit clock (one bit per rising edge)
//  rst_n : asynchronous active-low reset
//  bus   : spi_slave_ctrl_if.slave (ss_n, mosi, miso, rx_data, rx_valid, tx_data, tx_valid)
module spi_slave_ctrl #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_slave_ctrl_if.slave       bus
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    // cnt_q counts payload edges after the cmd-MSB edge; value LAST marks the bit-0 edge.
    localparam logic [3:0] LAST  = 4'(FRAME_W - 2);
    localparam logic [3:0] NBITS = 4'(DATA_W);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [FRAME_W-2:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_done_q, rd_addr_done_d;
    logic                 tx_done_q, tx_done_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0]    tx_sh_q, tx_sh_d;
    logic                 miso_q, miso_d;

    // State register (and all datapath flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_cnt_q       <= '0;
            tx_sh_q        <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_done_q      <= tx_done_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_sh_q        <= tx_sh_d;
            miso_q         <= miso_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (!bus.ss_n) state_d = CHK_CMD;
        end else if (bus.ss_n) begin
            state_d = IDLE;
        end else if (state_q == CHK_CMD) begin
            if (!bus.mosi)          state_d = WRITE;
            else if (rd_addr_done_q) state_d = READ_DATA;
            else                    state_d = READ_ADD;
        end
    end

    // Datapath / registered-output next values
    always_comb begin
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_done_d      = tx_done_q;
        tx_cnt_d       = tx_cnt_q;
        tx_sh_d        = tx_sh_q;
        miso_d         = miso_q;
        if (state_q == IDLE || bus.ss_n) begin
            // Abort or idle: drop any partial frame/byte, keep rd_addr_done as-is.
            cnt_d     = '0;
            tx_done_d = 1'b0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
        end else if (state_q == CHK_CMD) begin
            shift_d = {{(FRAME_W-2){1'b0}}, bus.mosi};
            cnt_d   = '0;
        end else begin
            if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
            if (cnt_q < LAST) begin
                shift_d = {shift_q[FRAME_W-3:0], bus.mosi};
            end else if (cnt_q == LAST) begin
                rx_data_d  = {shift_q, bus.mosi};
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            end else if (state_q == READ_DATA) begin
                // One byte per frame: tx_done blocks re-launch while tx_valid stays high.
                if (!tx_done_q) begin
                    if (bus.tx_valid) begin
                        miso_d    = bus.tx_data[DATA_W-1];
                        tx_sh_d   = {bus.tx_data[DATA_W-2:0], 1'b0};
                        tx_done_d = 1'b1;
                        tx_cnt_d  = 4'd1;
                    end
                end else if (tx_cnt_q < NBITS) begin
                    miso_d   = tx_sh_q[DATA_W-1];
                    tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                    tx_cnt_d = tx_cnt_q + 4'd1;
                end else if (tx_cnt_q == NBITS) begin
                    miso_d         = 1'b0;
                    rd_addr_done_d = 1'b0;
                    tx_cnt_d       = tx_cnt_q + 4'd1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.miso     = miso_q;
        bus.rx_data  = rx_data_q;
        bus.rx_valid = rx_valid_q;
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_slave_ctrl_if bus ();
    spi_slave_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Full frame: ss_n low at E0, bits 9..0 on E1..E10, check strobe E10 and its drop at E11.
    task automatic frame(input string tag, input logic [9:0] f, input bit keep_ss);
        int early = 0;
        @(negedge clk); bus.ss_n = 1'b0; bus.mosi = 1'b0;
        step();
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk); bus.mosi = f[i];
            step();
            if (i > 0 && bus.rx_valid) early++;
        end
        chk({tag, "_early"}, early, 0);
        chk({tag, "_rxv"}, bus.rx_valid, 1);
        chk({tag, "_rxd"}, bus.rx_data, f);
        @(negedge clk); bus.mosi = 1'b1;
        step();
        chk({tag, "_rxv_drop"}, bus.rx_valid, 0);
        if (!keep_ss) begin
            @(negedge clk); bus.ss_n = 1'b1;
            step();
        end
    endtask

    initial begin
        logic [7:0]  got_byte;
        logic [9:0]  pat;
        int          any;
        bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
        #12;
        chk("rst_miso", bus.miso, 0);
        chk("rst_rxv", bus.rx_valid, 0);
        chk("rst_rxd", bus.rx_data, 0);
        chk("rst_rd", dut.rd_addr_done_q, 0);
        @(negedge clk); rst_n = 1'b1;

        // 1/2: writes
        frame("wr_addr", 10'h03C, 1'b0);
        frame("wr_data", 10'h1A5, 1'b0);
        chk("wr_rd", dut.rd_addr_done_q, 0);

        // 3: read address sets rd_addr_done, survives ss_n high
        frame("rd_addr", 10'h23C, 1'b0);
        chk("rd_addr_done", dut.rd_addr_done_q, 1);

        // 4: read data, tx_valid held high, exactly one byte
        frame("rd_data", 10'h300, 1'b1);
        @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            step();
            got_byte[i] = bus.miso;
        end
        chk("miso_byte", got_byte, 8'hA5);
        step();
        chk("miso_end", bus.miso, 0);
        chk("rd_clr", dut.rd_addr_done_q, 0);
        any = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.miso) any++;
        end
        chk("miso_once", any, 0);
        @(negedge clk); bus.ss_n = 1'b1; bus.tx_valid = 1'b0;
        step();

        // 5: abort after 5 bits, abort on bit-0 edge, then clean frame
        any = 0;
        pat = 10'h155;
        @(negedge clk); bus.ss_n = 1'b0;
        step();
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk); bus.mosi = pat[i];
            step();
            if (bus.rx_valid) any++;
        end
        @(negedge clk); bus.ss_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.rx_valid) any++;
        end
        chk("abort5_rxv", any, 0);
        @(negedge clk); bus.ss_n = 1'b0;
        step();
        for (int i = 9; i >= 1; i--) begin
            @(negedge clk); bus.mosi = pat[i];
            step();
        end
        @(negedge clk); bus.mosi = pat[0]; bus.ss_n = 1'b1;
        step();
        chk("abort_b0_rxv", bus.rx_valid, 0);
        step();
        chk("abort_b0_rxv2", bus.rx_valid, 0);
        frame("after_abort", 10'h1FF, 1'b0);

        // 6: reset mid MISO byte
        frame("rd_addr2", 10'h23C, 1'b0);
        chk("rd_addr_done2", dut.rd_addr_done_q, 1);
        frame("rd_data2", 10'h3C3, 1'b1);
        @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
        step(); step(); step();
        chk("pre_rst_miso", bus.miso, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_miso", bus.miso, 0);
        chk("async_rxv", bus.rx_valid, 0);
        chk("async_rxd", bus.rx_data, 0);
        chk("async_rd", dut.rd_addr_done_q, 0);
        @(negedge clk); rst_n = 1'b1; bus.ss_n = 1'b1; bus.tx_valid = 1'b0;
        step();
        // cmd MSB=1 must now take READ_ADD: rd_addr_done sets, no byte sent even with tx_valid
        bus.tx_valid = 1'b1;
        frame("post_rst", 10'h2AA, 1'b1);
        chk("post_rst_rd", dut.rd_addr_done_q, 1);
        any = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.miso) any++;
        end
        chk("post_rst_miso", any, 0);
        @(negedge clk); bus.ss_n = 1'b1; bus.tx_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
